// File: rtl/jtag_dbg_pkg.sv
// ============================================================================
// Module  : jtag_dbg_pkg
// Brief   : Shared types, default widths and helpers for the JTAG debug bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package jtag_dbg_pkg;

   localparam int DEF_IR_W        = 2;
   localparam int DEF_DR_W        = 38;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int MAX_IR_W        = 8;

   localparam logic [1:0] C_ST_IDLE    = 2'd0;
   localparam logic [1:0] C_ST_CAPTURE = 2'd1;
   localparam logic [1:0] C_ST_SHIFT   = 2'd2;
   localparam logic [1:0] C_ST_UPDATE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = C_ST_IDLE,
      CAPTURE = C_ST_CAPTURE,
      SHIFT   = C_ST_SHIFT,
      UPDATE  = C_ST_UPDATE
   } dbg_state_e;

   // Sized for the widest supported IR; callers truncate to 2**IR_W.
   function automatic logic [2**MAX_IR_W-1:0] onehot_action(input logic [MAX_IR_W-1:0] ir);
      logic [2**MAX_IR_W-1:0] v;
      v     = '0;
      v[ir] = 1'b1;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_dbg_sync.sv
// ============================================================================
// Module  : jtag_dbg_sync
// Brief   : STAGES-deep synchroniser with a registered rising-edge strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_dbg_sync
   import jtag_dbg_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic rise
);

   logic [STAGES-1:0] r_pipe;
   logic              r_dly;
   logic              r_rise;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe <= '0;
         r_dly  <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_pipe <= {r_pipe[STAGES-2:0], d};
         r_dly  <= r_pipe[STAGES-1];
         r_rise <= r_pipe[STAGES-1] & ~r_dly;
      end
   end

   assign q    = r_pipe[STAGES-1];
   assign rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/jtag_debug_scan_bridge.sv
// ============================================================================
// Module  : jtag_debug_scan_bridge
// Brief   : clk-domain virtual-JTAG scan bridge delivering DR scans over
//           valid/ready. Optional even parity via JTAG_DBG_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_debug_scan_bridge
   import jtag_dbg_pkg::*;
#(
   parameter int IR_W        = DEF_IR_W,
   parameter int DR_W        = DEF_DR_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               tck,
   input  logic               tdi,
   input  logic               vs_cdr,
   input  logic               vs_sdr,
   input  logic               vs_udr,
   input  logic               vs_uir,
   input  logic [IR_W-1:0]    ir_in,
   input  logic [DR_W-1:0]    capture_data,
   output logic               tdo,
   output logic [DR_W-1:0]    jdo,
   output logic [IR_W-1:0]    jdo_ir,
   output logic               jdo_valid,
   input  logic               jdo_ready,
   output logic [2**IR_W-1:0] take_action,
   output logic               ir_update,
   output logic               overflow,
   output logic               short_scan,
`ifdef JTAG_DBG_PARITY_EN
   output logic               parity_err,
`endif
   input  logic               flag_clr
);

   localparam int ACT_W = 2**IR_W;
`ifdef JTAG_DBG_PARITY_EN
   localparam int SR_W  = DR_W + 1;
`else
   localparam int SR_W  = DR_W;
`endif
   localparam int              CNT_W      = $clog2(SR_W + 1);
   localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(SR_W);

   logic [5:0] w_pin;
   logic [5:0] w_sync;
   logic [5:0] w_rise;

   assign w_pin = {vs_uir, vs_udr, vs_sdr, vs_cdr, tdi, tck};

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_sync
         jtag_dbg_sync #(
            .STAGES (SYNC_STAGES)
         ) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (w_pin[gi]),
            .q       (w_sync[gi]),
            .rise    (w_rise[gi])
         );
      end
   endgenerate

   logic w_tck_rise, w_tdi_s, w_cdr_s, w_sdr_s, w_udr_rise, w_uir_rise;
   logic w_unused;

   assign w_tck_rise = w_rise[0];
   assign w_tdi_s    = w_sync[1];
   assign w_cdr_s    = w_sync[2];
   assign w_sdr_s    = w_sync[3];
   assign w_udr_rise = w_rise[4];
   assign w_uir_rise = w_rise[5];
   assign w_unused   = ^{w_sync[0], w_sync[5:4], w_rise[3:1]};

   dbg_state_e        r_state;
   logic [SR_W-1:0]   r_sr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_tdo;
   logic [DR_W-1:0]   r_jdo;
   logic [IR_W-1:0]   r_jdo_ir;
   logic              r_jdo_valid;
   logic [ACT_W-1:0]  r_take_action;
   logic              r_ir_update;
   logic              r_overflow;
   logic              r_short_scan;

   logic [SR_W-1:0]   w_capture_val;
   logic              w_parity_ok;
   logic              w_full;
   logic              w_accept;
   logic              w_deliver;
   logic              w_overflow_set;
   logic              w_short_set;
   logic [ACT_W-1:0]  w_action;

`ifdef JTAG_DBG_PARITY_EN
   logic              r_parity_err;
   logic              w_parity_set;

   // Bit DR_W holds even parity, so a good scan XORs to zero overall.
   assign w_capture_val = {^capture_data, capture_data};
   assign w_parity_ok   = ~(^r_sr);
   assign w_parity_set  = w_udr_rise & w_full & ~w_parity_ok;
   assign parity_err    = r_parity_err;
`else
   assign w_capture_val = capture_data;
   assign w_parity_ok   = 1'b1;
`endif

   assign w_full         = (r_cnt == C_CNT_FULL);
   assign w_accept       = ~r_jdo_valid | jdo_ready;
   assign w_short_set    = w_udr_rise & ~w_full;
   assign w_deliver      = w_udr_rise & w_full & w_parity_ok & w_accept;
   assign w_overflow_set = w_udr_rise & w_full & w_parity_ok & ~w_accept;
   assign w_action       = ACT_W'(onehot_action(MAX_IR_W'(ir_in)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
      end else if (w_udr_rise) begin
         r_state <= UPDATE;
      end else begin
         case (r_state)
            IDLE, CAPTURE, SHIFT: begin
               if (w_tck_rise & w_cdr_s) begin
                  r_state <= CAPTURE;
                  r_sr    <= w_capture_val;
                  r_cnt   <= '0;
               end else if (w_tck_rise & w_sdr_s & (r_state != IDLE)) begin
                  r_state <= SHIFT;
                  r_sr    <= {w_tdi_s, r_sr[SR_W-1:1]};
                  if (r_cnt != C_CNT_FULL) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            UPDATE:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tdo         <= 1'b0;
         r_jdo         <= '0;
         r_jdo_ir      <= '0;
         r_jdo_valid   <= 1'b0;
         r_take_action <= '0;
         r_ir_update   <= 1'b0;
         r_overflow    <= 1'b0;
         r_short_scan  <= 1'b0;
      end else begin
         r_tdo       <= r_sr[0];
         r_ir_update <= w_uir_rise;
         // A load in the same cycle as an accept keeps valid asserted.
         if (w_deliver) begin
            r_jdo       <= r_sr[DR_W-1:0];
            r_jdo_ir    <= ir_in;
            r_jdo_valid <= 1'b1;
         end else if (r_jdo_valid & jdo_ready) begin
            r_jdo_valid <= 1'b0;
         end
         r_take_action <= w_deliver ? w_action : '0;
         if (w_overflow_set) begin
            r_overflow <= 1'b1;
         end else if (flag_clr) begin
            r_overflow <= 1'b0;
         end
         if (w_short_set) begin
            r_short_scan <= 1'b1;
         end else if (flag_clr) begin
            r_short_scan <= 1'b0;
         end
      end
   end

`ifdef JTAG_DBG_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_parity_err <= 1'b0;
      end else if (w_parity_set) begin
         r_parity_err <= 1'b1;
      end else if (flag_clr) begin
         r_parity_err <= 1'b0;
      end
   end
`endif

   assign tdo         = r_tdo;
   assign jdo         = r_jdo;
   assign jdo_ir      = r_jdo_ir;
   assign jdo_valid   = r_jdo_valid;
   assign take_action = r_take_action;
   assign ir_update   = r_ir_update;
   assign overflow    = r_overflow;
   assign short_scan  = r_short_scan;

endmodule

`default_nettype wire

// File: tb/tb_jtag_debug_scan_bridge.sv
// ============================================================================
// Module  : tb_jtag_debug_scan_bridge
// Brief   : Directed self-checking bench for jtag_debug_scan_bridge
//           (parity scenario built when JTAG_DBG_PARITY_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_debug_scan_bridge;

   localparam int IR_W = 2;
   localparam int DR_W = 38;

   localparam logic [DR_W-1:0] C_W0 = 38'h2A_DEAD_BEEF;
   localparam logic [DR_W-1:0] C_V  = 38'h15_A5A5_F0F1;
   localparam logic [DR_W-1:0] C_W1 = 38'h11_2233_4455;
   localparam logic [DR_W-1:0] C_W2 = 38'h0F_0F0F_0F0F;
   localparam logic [DR_W-1:0] C_W3 = 38'h3F_FFFF_0001;

   logic              clk          = 1'b0;
   logic              reset_n      = 1'b0;
   logic              tck          = 1'b0;
   logic              tdi          = 1'b0;
   logic              vs_cdr       = 1'b0;
   logic              vs_sdr       = 1'b0;
   logic              vs_udr       = 1'b0;
   logic              vs_uir       = 1'b0;
   logic [IR_W-1:0]   ir_in        = '0;
   logic [DR_W-1:0]   capture_data = '0;
   logic              jdo_ready    = 1'b0;
   logic              flag_clr     = 1'b0;
   logic              tdo;
   logic [DR_W-1:0]   jdo;
   logic [IR_W-1:0]   jdo_ir;
   logic              jdo_valid;
   logic [2**IR_W-1:0] take_action;
   logic              ir_update;
   logic              overflow;
   logic              short_scan;
`ifdef JTAG_DBG_PARITY_EN
   logic              parity_err;
`endif

   int                n_chk  = 0;
   int                n_pass = 0;
   int                n_fail = 0;
   logic [3:0]        ta_seen;
   int                ta_cnt;
   int                iru_cnt;

   jtag_debug_scan_bridge #(
      .IR_W        (IR_W),
      .DR_W        (DR_W),
      .SYNC_STAGES (2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tck          (tck),
      .tdi          (tdi),
      .vs_cdr       (vs_cdr),
      .vs_sdr       (vs_sdr),
      .vs_udr       (vs_udr),
      .vs_uir       (vs_uir),
      .ir_in        (ir_in),
      .capture_data (capture_data),
      .tdo          (tdo),
      .jdo          (jdo),
      .jdo_ir       (jdo_ir),
      .jdo_valid    (jdo_valid),
      .jdo_ready    (jdo_ready),
      .take_action  (take_action),
      .ir_update    (ir_update),
      .overflow     (overflow),
      .short_scan   (short_scan),
`ifdef JTAG_DBG_PARITY_EN
      .parity_err   (parity_err),
`endif
      .flag_clr     (flag_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tck_pulse();
      tck = 1'b1;
      cyc(4);
      tck = 1'b0;
      cyc(4);
   endtask

   task automatic do_capture(input logic [DR_W-1:0] d);
      capture_data = d;
      vs_cdr = 1'b1;
      tck_pulse();
      vs_cdr = 1'b0;
   endtask

   task automatic shift_bits(input logic [63:0] d, input int n);
      vs_sdr = 1'b1;
      for (int i = 0; i < n; i++) begin
         tdi = d[i];
         tck_pulse();
      end
      vs_sdr = 1'b0;
      tdi    = 1'b0;
   endtask

   task automatic do_scan(input logic [DR_W-1:0] d);
      do_capture('0);
      shift_bits(64'(d), DR_W);
`ifdef JTAG_DBG_PARITY_EN
      shift_bits({63'b0, ^d}, 1);
`endif
   endtask

   // Optionally raises jdo_ready for the one cycle in which the update edge is acted on.
   task automatic do_update(input logic [IR_W-1:0] ir, input bit pulse_ready);
      ir_in   = ir;
      vs_udr  = 1'b1;
      ta_seen = '0;
      ta_cnt  = 0;
      for (int i = 0; i < 12; i++) begin
         if (pulse_ready && i == 3) jdo_ready = 1'b1;
         if (pulse_ready && i == 4) jdo_ready = 1'b0;
         if (i == 6) vs_udr = 1'b0;
         cyc(1);
         ta_seen = ta_seen | take_action;
         if (take_action != '0) ta_cnt++;
      end
   endtask

   initial begin
      // Reset state
      cyc(3);
      chk("rst_tdo",        64'(tdo),         64'd0);
      chk("rst_jdo",        64'(jdo),         64'd0);
      chk("rst_jdo_valid",  64'(jdo_valid),   64'd0);
      chk("rst_take",       64'(take_action), 64'd0);
      chk("rst_flags",      64'({overflow, short_scan, ir_update}), 64'd0);
      reset_n = 1'b1;
      cyc(3);

      // Update-IR pulse
      vs_uir  = 1'b1;
      iru_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) vs_uir = 1'b0;
         cyc(1);
         if (ir_update) iru_cnt++;
      end
      chk("ir_update_pulse", 64'(iru_cnt), 64'd1);

      // Full scan, held by consumer
      do_scan(C_W0);
      do_update(2'd2, 1'b0);
      chk("full_jdo",       64'(jdo),       64'(C_W0));
      chk("full_jdo_ir",    64'(jdo_ir),    64'd2);
      chk("full_valid",     64'(jdo_valid), 64'd1);
      chk("full_ta",        64'(ta_seen),   64'h4);
      chk("full_ta_cnt",    64'(ta_cnt),    64'd1);
      chk("full_flags",     64'({overflow, short_scan}), 64'd0);
      jdo_ready = 1'b1;
      cyc(1);
      jdo_ready = 1'b0;
      chk("accept_clears",  64'(jdo_valid), 64'd0);
      chk("jdo_kept",       64'(jdo),       64'(C_W0));

      // tdo follows capture then shifted bits
      do_capture(38'h1);
      chk("tdo_capture",    64'(tdo), 64'd1);
      shift_bits(64'(C_V), 1);
      chk("tdo_shift1",     64'(tdo), 64'd0);
      shift_bits(64'(C_V) >> 1, DR_W - 1);
`ifdef JTAG_DBG_PARITY_EN
      shift_bits({63'b0, ^C_V}, 1);
`endif
      chk("tdo_shift_all",  64'(tdo), 64'd1);
      jdo_ready = 1'b1;
      do_update(2'd1, 1'b0);
      jdo_ready = 1'b0;
      chk("tdo_scan_jdo",   64'(jdo),       64'(C_V));
      chk("tdo_scan_ta",    64'(ta_seen),   64'h2);
      chk("tdo_scan_valid", 64'(jdo_valid), 64'd0);

      // Short scan
      do_capture('0);
      shift_bits(64'hF_FFFF, 20);
      do_update(2'd0, 1'b0);
      chk("short_flag",     64'(short_scan), 64'd1);
      chk("short_novalid",  64'(jdo_valid),  64'd0);
      chk("short_no_ta",    64'(ta_cnt),     64'd0);
      flag_clr = 1'b1;
      cyc(1);
      flag_clr = 1'b0;
      chk("short_cleared",  64'(short_scan), 64'd0);

      // Overflow while held
      do_scan(C_W1);
      do_update(2'd0, 1'b0);
      chk("ovf_first_jdo",  64'(jdo), 64'(C_W1));
      do_scan(C_W2);
      do_update(2'd3, 1'b0);
      chk("ovf_flag",       64'(overflow), 64'd1);
      chk("ovf_jdo_held",   64'(jdo),      64'(C_W1));
      chk("ovf_jdo_ir",     64'(jdo_ir),   64'd0);
      chk("ovf_no_ta",      64'(ta_cnt),   64'd0);
      flag_clr = 1'b1;
      cyc(1);
      flag_clr = 1'b0;
      chk("ovf_cleared",    64'(overflow), 64'd0);

      // Accept and load in the same cycle
      do_scan(C_W2);
      do_update(2'd3, 1'b1);
      chk("swap_jdo",       64'(jdo),       64'(C_W2));
      chk("swap_valid",     64'(jdo_valid), 64'd1);
      chk("swap_ovf",       64'(overflow),  64'd0);
      chk("swap_ta",        64'(ta_seen),   64'h8);

      // Reset mid-scan
      do_capture('0);
      shift_bits(64'h3FF, 10);
      reset_n = 1'b0;
      cyc(2);
      chk("mid_rst_jdo",    64'(jdo),         64'd0);
      chk("mid_rst_valid",  64'(jdo_valid),   64'd0);
      chk("mid_rst_misc",   64'({tdo, jdo_ir, take_action, ir_update, overflow, short_scan}), 64'd0);
      reset_n = 1'b1;
      cyc(2);
      do_scan(C_W3);
      do_update(2'd2, 1'b0);
      chk("post_rst_jdo",   64'(jdo),       64'(C_W3));
      chk("post_rst_valid", 64'(jdo_valid), 64'd1);
      chk("post_rst_ta",    64'(ta_seen),   64'h4);
      jdo_ready = 1'b1;
      cyc(1);
      jdo_ready = 1'b0;

`ifdef JTAG_DBG_PARITY_EN
      // Wrong parity bit: ^3 is 0, bit shifted in is 1
      do_capture('0);
      shift_bits(64'h3, DR_W);
      shift_bits(64'h1, 1);
      do_update(2'd1, 1'b0);
      chk("par_err",        64'(parity_err), 64'd1);
      chk("par_novalid",    64'(jdo_valid),  64'd0);
      chk("par_no_ta",      64'(ta_cnt),     64'd0);
      flag_clr = 1'b1;
      cyc(1);
      flag_clr = 1'b0;
      chk("par_cleared",    64'(parity_err), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
